// File: rtl/spi_reg_receiver.sv
// SPI mode-0 write-command receiver holding five 8-bit PWM control registers.
// Optional readback path on cipo is built when SPI_READBACK_EN is defined.
module spi_reg_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       cs_n,
  output logic       cipo,
  output logic [7:0] reg_0,
  output logic [7:0] reg_1,
  output logic [7:0] reg_2,
  output logic [7:0] reg_3,
  output logic [7:0] reg_4,
  output logic       wr_strobe,
  output logic [6:0] wr_addr
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  localparam int              NUM_REGS   = 5;
  localparam logic [6:0]      MAX_ADDR_L = 7'(MAX_ADDR);
  localparam logic [6:0]      NUM_REGS_L = 7'(NUM_REGS);
  localparam int              SETTLE     = SYNC_STAGES + 1;
  localparam int              SW         = $clog2(SETTLE + 1);
  localparam logic [SW-1:0]   SETTLE_L   = SW'(SETTLE);

  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, cs_n_sync;
  logic                   sclk_d, cs_n_d;
  logic                   sclk_s, copi_s, cs_n_s;
  logic                   sclk_rise, cs_fall, cs_rise;
  logic [SW-1:0]          settle_cnt;
  logic                   armed;

  state_t      state, state_next;
  logic        frame_start, shift_en, commit_en, frame_ok;
  logic [15:0] shift_reg;
  logic [4:0]  bit_cnt;
  logic [7:0]  regs [NUM_REGS];

  // NOTE: every clocked process uses non-blocking assignments so all flops
  // update together and simulation order cannot change the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      cs_n_sync <= '1;
      sclk_d    <= 1'b0;
      cs_n_d    <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], cs_n};
      sclk_d    <= sclk_s;
      cs_n_d    <= cs_n_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign cs_n_s    = cs_n_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_rise   = cs_n_s & ~cs_n_d;
  assign cs_fall   = ~cs_n_s & cs_n_d & armed;

  // The synchronizer resets to cs_n=1, so a pin held low at reset release would
  // look like a falling edge. Frames are only accepted once the chain has
  // flushed and a genuine high level on cs_n has been seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      armed      <= 1'b0;
    end else begin
      if (settle_cnt != SETTLE_L) settle_cnt <= settle_cnt + 1'b1;
      else if (cs_n_s)            armed      <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  assign frame_ok = (bit_cnt == 5'd16) && shift_reg[15] &&
                    (shift_reg[14:8] <= MAX_ADDR_L) && (shift_reg[14:8] < NUM_REGS_L);

  // NOTE: every output of this block gets a default before the case so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    shift_en    = 1'b0;
    commit_en   = 1'b0;
    unique case (state)
      IDLE: if (cs_fall) begin
        frame_start = 1'b1;
        state_next  = SHIFT;
      end
      SHIFT: begin
        // A cs_n rise wins over an sclk rise seen in the same cycle.
        if (cs_rise) begin
          commit_en  = frame_ok;
          state_next = COMMIT;
        end else if (sclk_rise && bit_cnt != 5'd16) begin
          shift_en = 1'b1;
        end
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the register file is reset because its contents drive the PWM
  // peripheral directly; a bulk memory without that need would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= commit_en;
      if (frame_start) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else if (shift_en) begin
        shift_reg <= {shift_reg[14:0], copi_s};
        bit_cnt   <= bit_cnt + 5'd1;
      end
      if (commit_en) begin
        regs[shift_reg[10:8]] <= shift_reg[7:0];
        wr_addr               <= shift_reg[14:8];
      end
    end
  end

  assign reg_0 = regs[0];
  assign reg_1 = regs[1];
  assign reg_2 = regs[2];
  assign reg_3 = regs[3];
  assign reg_4 = regs[4];

`ifdef SPI_READBACK_EN
  logic       sclk_fall, rd_en;
  logic [7:0] rd_shift;
  logic [6:0] rd_addr;

  assign sclk_fall = ~sclk_s & sclk_d;
  // Address as it will stand once the 8th bit lands this cycle.
  assign rd_addr   = {shift_reg[5:0], copi_s};

  // The MSB is presented at the 8th rising edge; shifting starts on the fall
  // after the 9th rise so the master sees bit 8 on its 9th sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en    <= 1'b0;
      rd_shift <= '0;
    end else if (frame_start) begin
      rd_en    <= 1'b0;
      rd_shift <= '0;
    end else if (shift_en && bit_cnt == 5'd7 && !shift_reg[6]) begin
      rd_en    <= 1'b1;
      rd_shift <= (rd_addr <= MAX_ADDR_L && rd_addr < NUM_REGS_L) ? regs[rd_addr[2:0]] : 8'h00;
    end else if (state == SHIFT && rd_en && sclk_fall &&
                 bit_cnt >= 5'd9 && bit_cnt <= 5'd15) begin
      rd_shift <= {rd_shift[6:0], 1'b0};
    end
  end

  assign cipo = (state == SHIFT) && rd_en && rd_shift[7];
`else
  assign cipo = 1'b0;
`endif

endmodule
